// File: rtl/mc_controller_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
// FSM states, opcode/funct constants, ALU codes and mux select encodings.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_REGB  = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_controller_aludec.sv
// ALU decoder: maps aluop (from the FSM) and funct (from the IR) to alucontrol.
// Ports: aluop in, funct in, alucontrol out. Purely combinational.
module mc_aludec
    import mc_controller_pkg::*;
#(
    parameter int FNWIDTH = 6,
    parameter int ACWIDTH = 3
) (
    input  logic [1:0]         aluop,
    input  logic [FNWIDTH-1:0] funct,
    output logic [ACWIDTH-1:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    // unknown funct still writes back an add result
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore FSM driving the shared-memory/shared-ALU datapath.
// Ports: clk, reset (async, active-high), op, funct, zero in; mux selects, strobes,
// alucontrol, pcen and the illegal-opcode pulse out.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int OPWIDTH = 6,
    parameter int FNWIDTH = 6,
    parameter int ACWIDTH = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [OPWIDTH-1:0] op,
    input  logic [FNWIDTH-1:0] funct,
    input  logic               zero,
    output logic               iord,
    output logic               memwrite,
    output logic               irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic [ACWIDTH-1:0] alucontrol,
    output logic               pcen,
    output logic               illegal
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] aluop;
    logic       mw;
    logic       irw;
    logic       rw;
    logic       pcw;
    logic       br;
    logic       ill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d  = FETCH;
        iord     = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = ALUSRCB_REGB;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        mw       = 1'b0;
        irw      = 1'b0;
        rw       = 1'b0;
        pcw      = 1'b0;
        br       = 1'b0;
        ill      = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb = ALUSRCB_FOUR;
                irw     = 1'b1;
                pcw     = 1'b1;
                state_d = DECODE;
            end
            DECODE: begin
                alusrcb = ALUSRCB_IMMSH;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        ill     = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                state_d = (op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                iord    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                rw       = 1'b1;
            end
            MEMWR: begin
                iord = 1'b1;
                mw   = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                state_d = RTYPEWB;
            end
            RTYPEWB: begin
                regdst = 1'b1;
                rw     = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = PCSRC_ALUOUT;
                br      = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = ALUSRCB_IMM;
                state_d = ADDIWB;
            end
            ADDIWB: rw = 1'b1;
            JEX: begin
                pcsrc = PCSRC_JUMP;
                pcw   = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // strobes are masked by reset so an aborted instruction cannot write anything
    assign memwrite = mw & ~reset;
    assign irwrite  = irw & ~reset;
    assign regwrite = rw & ~reset;
    assign illegal  = ill & ~reset;
    assign pcen     = (pcw | (br & zero)) & ~reset;

    mc_aludec #(
        .FNWIDTH(FNWIDTH),
        .ACWIDTH(ACWIDTH)
    ) u_aludec (
        .aluop     (aluop),
        .funct     (funct),
        .alucontrol(alucontrol)
    );

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control unit for the 32-bit MIPS core. It replaces the single-cycle combinational controller when the datapath shares one memory and one ALU across several cycles per instruction. It is a Moore FSM that steps through the fetch, decode, execute, memory and writeback states. Each cycle it drives the mux selects, write strobes and ALU control of the multicycle datapath.

Parameters:
OPWIDTH, 6, opcode field width (instr[31:26])
FNWIDTH, 6, funct field width (instr[5:0])
ACWIDTH, 3, alucontrol width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
op  input  OPWIDTH  opcode from instruction register
funct  input  FNWIDTH  funct from instruction register
zero  input  1  ALU zero flag, combinational from datapath
iord  output  1  memory address select: 0=PC, 1=ALUOut
memwrite  output  1  data memory write strobe
irwrite  output  1  instruction register load enable
regdst  output  1  register write address: 0=rt, 1=rd
memtoreg  output  1  register write data: 0=ALUOut, 1=Data
regwrite  output  1  register file write strobe
alusrca  output  1  ALU A select: 0=PC, 1=regA
alusrcb  output  2  ALU B select: 00=regB, 01=4, 10=SignImm, 11=SignImm<<2
pcsrc  output  2  PC next select: 00=ALUResult, 01=ALUOut, 10=jump target
alucontrol  output  ACWIDTH  ALU operation
pcen  output  1  PC load enable = pcwrite | (branch & zero)
illegal  output  1  one-cycle pulse when an unsupported opcode is decoded

Behaviour:
- State register is updated on posedge clk. Asynchronous reset forces FETCH.
- While reset is high: pcen, irwrite, memwrite, regwrite and illegal are 0. All other outputs take FETCH values.
- States and Moore outputs. Any output not listed is 0.
  - FETCH: alusrcb=01, aluop=00, irwrite=1, pcwrite=1.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- Transitions:
  - FETCH->DECODE.
  - DECODE by op:
    - lw 100011 or sw 101011 -> MEMADR.
    - R-type 000000 -> RTYPEEX.
    - beq 000100 -> BEQEX.
    - addi 001000 -> ADDIEX.
    - j 000010 -> JEX.
    - any other op -> FETCH, with illegal=1 during that DECODE cycle only.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD->MEMWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB and JEX -> FETCH.
  - RTYPEEX->RTYPEWB.
  - ADDIEX->ADDIWB.
- Cycle counts, including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- pcen is combinational on zero; in BEQEX it is high only if zero=1.
- alucontrol (ALU decode):
  - aluop 00 -> 010 (add).
  - aluop 01 -> 110 (sub).
  - aluop 10 by funct:
    - 100000 -> 010.
    - 100010 -> 110.
    - 100100 -> 000.
    - 100101 -> 001.
    - 101010 -> 111.
    - any other funct -> 010. The writeback still happens; illegal is not asserted.
  - aluop 11 is unused and decodes to 010.
- Unused state encodings -> FETCH on the next clock.
- Reset asserted mid-instruction aborts it. No strobe fires while reset is high. FETCH is the first state after reset release.
- op and funct are sampled only in DECODE and MEMADR (op), and in RTYPEEX (funct). The IR holds them stable because irwrite=0 outside FETCH.

Decomposition:
- Shared package holds:
  - state enumeration: 4-bit, FETCH=0 through JEX=11;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT;
  - ALU control codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - ALUSRCB_* and PCSRC_* select encodings.
- One sub-module, mc_aludec: a combinational map from aluop and funct to alucontrol, shared with the single-cycle controller style.
- The FSM and output decode stay in mc_controller.

Test Plan:
- Reset high for 2 cycles then low; op=100011 (lw) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH.
  - FETCH: pcen=1, irwrite=1, alusrcb=01, alucontrol=010.
  - MEMRD: iord=1.
  - MEMWB: regwrite=1, memtoreg=1, regdst=0.
- op=101011 (sw) -> 4 cycles; memwrite=1 only in the 4th cycle, with iord=1; regwrite never 1.
- op=000000, funct=101010 (slt) -> alucontrol=111 and alusrca=1 in RTYPEEX; then regwrite=1, regdst=1 in RTYPEWB.
- op=000100 (beq): with zero=1 -> pcen=1 and pcsrc=01 in the 3rd cycle; repeat with zero=0 -> pcen=0 throughout except FETCH.
- op=000010 (j) -> pcen=1 and pcsrc=10 in the 3rd cycle. op=111111 -> illegal=1 for exactly the DECODE cycle, then FETCH.
- Assert reset asynchronously mid-cycle in MEMWR -> memwrite drops to 0 immediately (no clock edge); after release, the first state is FETCH with pcen=1.
